// File: rtl/ysyx_22040931_bpu_pkg.sv
// Shared constants for the fetch-side branch predictor: bus width,
// BTB depth and the 2-bit saturating counter encodings.
package ysyx_22040931_bpu_pkg;

    localparam int PC_BUS      = 64;
    localparam int BTB_ENTRIES = 16;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

endpackage

// File: rtl/ysyx_22040931_bpu_sat_ctr2.sv
// 2-bit saturating counter next-state: increments on taken, decrements on
// not-taken, clamped to strongly-not-taken / strongly-taken.
module ysyx_22040931_sat_ctr2
    import ysyx_22040931_bpu_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        // NOTE: default first so every path assigns ctr_nxt and no latch is inferred.
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/ysyx_22040931_bpu.sv
// Direct-mapped BTB with 2-bit counters: registered next-PC guess for IF,
// trained by resolved B-type outcomes from EX.
module ysyx_22040931_bpu
    import ysyx_22040931_bpu_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 8,
    parameter int PC_W    = PC_BUS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [PC_W-1:0] req_pc,
    input  logic            stall,
    input  logic            flush,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);

    logic             v_q   [ENTRIES];
    logic [1:0]       ctr_q [ENTRIES];
    logic [TAG_W-1:0] tag_q [ENTRIES];
    logic [PC_W-1:0]  tgt_q [ENTRIES];

    logic [IDX_W-1:0] req_idx, upd_idx;
    logic [TAG_W-1:0] req_tag, upd_tag;
    logic             req_hit, upd_hit, req_taken;
    logic [1:0]       upd_ctr_nxt;
    logic             pc_bits_unused;

    assign req_idx = req_pc[IDX_W+1:2];
    assign req_tag = req_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Upper PC bits and the halfword offset play no part in indexing or tagging.
    assign pc_bits_unused = ^{upd_pc[PC_W-1:IDX_W+TAG_W+2], upd_pc[1:0]};

    assign req_hit   = v_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign req_taken = req_hit && ctr_q[req_idx][1];
    assign upd_hit   = v_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    ysyx_22040931_sat_ctr2 u_sat_ctr2 (
        .ctr     (ctr_q[upd_idx]),
        .taken   (upd_taken),
        .ctr_nxt (upd_ctr_nxt)
    );

    // NOTE: sequential state uses non-blocking assignments so a same-edge
    // lookup reads the pre-update entry, which is exactly the no-bypass rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                v_q[i]   <= 1'b0;
                ctr_q[i] <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= upd_ctr_nxt;
            end else if (upd_taken) begin
                v_q[upd_idx]   <= 1'b1;
                ctr_q[upd_idx] <= CTR_WT;
            end
        end
    end

    // NOTE: tag/target storage is left unreset; v_q masks it until first allocation.
    always_ff @(posedge clk) begin
        if (upd_valid && upd_taken) begin
            tag_q[upd_idx] <= upd_tag;
            tgt_q[upd_idx] <= upd_target;
        end
    end

    // Flush outranks stall; stall freezes every prediction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (flush) begin
            pred_valid <= 1'b0;
        end else if (!stall) begin
            if (req_valid) begin
                pred_valid  <= 1'b1;
                pred_taken  <= req_taken;
                pred_target <= req_taken ? tgt_q[req_idx] : req_pc + PC_W'(4);
            end else begin
                pred_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_bpu.sv
// Directed self-checking bench for ysyx_22040931_bpu: allocation, counter
// hysteresis, tag conflicts, same-cycle hazard, stall/flush and reset.
module tb_ysyx_22040931_bpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, stall, flush;
    logic [63:0] req_pc;
    logic        pred_valid, pred_taken;
    logic [63:0] pred_target;
    logic        upd_valid, upd_taken;
    logic [63:0] upd_pc, upd_target;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22040931_bpu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .stall       (stall),
        .flush       (flush),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs set afterwards apply at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [63:0] pc,
                          input logic exp_taken, input logic [63:0] exp_tgt);
        req_valid = 1'b1;
        req_pc    = pc;
        step();
        req_valid = 1'b0;
        check({tag, ".valid"},  pred_valid,  1'b1);
        check({tag, ".taken"},  pred_taken,  exp_taken);
        check({tag, ".target"}, pred_target, exp_tgt);
    endtask

    task automatic update(input logic [63:0] pc, input logic taken, input logic [63:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        step();
        upd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        req_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        #12;
        check("rst.valid",  pred_valid,  1'b0);
        check("rst.taken",  pred_taken,  1'b0);
        check("rst.target", pred_target, 64'h0);
        rst_n = 1'b1;
        step();

        lookup("first", 64'h8000_0000, 1'b0, 64'h8000_0004);
        step();
        check("idle.valid", pred_valid, 1'b0);

        // Allocation at ctr=10, then hysteresis walk.
        update(64'h8000_0010, 1'b1, 64'h8000_0100);
        lookup("alloc", 64'h8000_0010, 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b0, 64'h0);
        lookup("ctr01", 64'h8000_0010, 1'b0, 64'h8000_0014);
        update(64'h8000_0010, 1'b0, 64'h0);
        lookup("ctr00", 64'h8000_0010, 1'b0, 64'h8000_0014);
        update(64'h8000_0010, 1'b0, 64'h0);
        lookup("ctr00sat", 64'h8000_0010, 1'b0, 64'h8000_0014);
        update(64'h8000_0010, 1'b1, 64'h8000_0180);
        lookup("up01", 64'h8000_0010, 1'b0, 64'h8000_0014);
        update(64'h8000_0010, 1'b1, 64'h8000_0100);
        lookup("up10", 64'h8000_0010, 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b0, 64'h0);
        lookup("ctr11sat", 64'h8000_0010, 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b0, 64'h0);
        lookup("down01", 64'h8000_0010, 1'b0, 64'h8000_0014);

        // Same idx, different tag.
        update(64'h8000_0010, 1'b1, 64'h8000_0100);
        update(64'h8000_0010, 1'b1, 64'h8000_0100);
        lookup("conf.pre", 64'h8000_0010, 1'b1, 64'h8000_0100);
        lookup("conf.miss", 64'h8000_0410, 1'b0, 64'h8000_0414);
        update(64'h8000_0410, 1'b0, 64'h0);
        lookup("conf.ntkeep", 64'h8000_0010, 1'b1, 64'h8000_0100);
        update(64'h8000_0410, 1'b1, 64'h8000_0200);
        lookup("conf.new", 64'h8000_0410, 1'b1, 64'h8000_0200);
        lookup("conf.old", 64'h8000_0010, 1'b0, 64'h8000_0014);

        // Lookup and allocation of the same entry on one edge.
        req_valid = 1'b1; req_pc = 64'h8000_0020;
        upd_valid = 1'b1; upd_pc = 64'h8000_0020; upd_taken = 1'b1; upd_target = 64'h8000_0300;
        step();
        upd_valid = 1'b0;
        check("hazard.taken",  pred_taken,  1'b0);
        check("hazard.target", pred_target, 64'h8000_0024);
        step();
        check("hazard2.taken",  pred_taken,  1'b1);
        check("hazard2.target", pred_target, 64'h8000_0300);

        // Stall freezes outputs while req_pc wanders.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_pc = 64'h8000_0000 + 64'(i * 4);
            step();
            check("stall.valid",  pred_valid,  1'b1);
            check("stall.taken",  pred_taken,  1'b1);
            check("stall.target", pred_target, 64'h8000_0300);
        end
        flush = 1'b1;
        step();
        check("flush.valid", pred_valid, 1'b0);
        flush = 1'b0; stall = 1'b0; req_valid = 1'b0;

        lookup("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

        // Asynchronous reset mid-cycle clears state immediately.
        lookup("prerst", 64'h8000_0020, 1'b1, 64'h8000_0300);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid", pred_valid, 1'b0);
        check("arst.taken", pred_taken, 1'b0);
        #3 rst_n = 1'b1;
        step();
        check("postrst.idle", pred_valid, 1'b0);
        lookup("postrst.a", 64'h8000_0020, 1'b0, 64'h8000_0024);
        lookup("postrst.b", 64'h8000_0410, 1'b0, 64'h8000_0414);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22040931_bpu.md
Name: ysyx_22040931_bpu

Overview:
- Fetch-side branch prediction unit: the predicting end of the B-type branch decision that the execute stage resolves.
- Direct-mapped branch target buffer with per-entry 2-bit saturating counters.
- Looked up by the IF-stage PC; trained by resolved B-type outcomes (beq/bne/blt/bge/bltu/bgeu) from EX.
- Gives IF a registered next-PC guess one cycle after each request.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..64.
- IDX_W, 4, log2(ENTRIES).
- TAG_W, 8, stored tag bits taken from the PC above the index.
- PC_W, 64, PC/target width (matches DATA_BUS).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  IF presents a PC for lookup.
- req_pc  in  PC_W  fetch PC.
- stall  in  1  IF stalled; hold prediction registers.
- flush  in  1  pipeline redirect; kill the pending prediction.
- pred_valid  out  1  prediction for the last accepted req_pc is present.
- pred_taken  out  1  predicted taken.
- pred_target  out  PC_W  predicted next PC.
- upd_valid  in  1  EX resolved a B-type instruction this cycle (driven from btype).
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome (driven from jump).
- upd_target  in  PC_W  computed branch target.

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: v (1), tag (TAG_W), ctr (2), tgt (PC_W).
- Reset (rst_n low, asynchronous):
  - All v = 0, all ctr = 2'b01.
  - pred_valid = 0, pred_taken = 0, pred_target = 0.
  - tag and tgt need no reset.
- Lookup (1-cycle latency): at the edge where req_valid=1, stall=0, flush=0:
  - hit = v[idx] & (tag[idx] == req tag).
  - pred_valid <= 1.
  - pred_taken <= hit & ctr[idx][1].
  - pred_target <= pred_taken ? tgt[idx] : req_pc + 4. Addition is PC_W bits and wraps modulo 2^PC_W.
- Edges without a new lookup:
  - req_valid=0, stall=0, flush=0: pred_valid <= 0; other outputs don't care but hold.
  - stall=1, flush=0: all pred_* registers hold; req is ignored.
  - flush=1: pred_valid <= 0 regardless of stall or req_valid. Flush has priority over stall.
- Update (takes effect at the clock edge, independent of stall/flush): when upd_valid=1, using idx/tag of upd_pc:
  - Hit, taken: ctr <= sat_inc(ctr) (max 2'b11); tgt <= upd_target.
  - Hit, not taken: ctr <= sat_dec(ctr) (min 2'b00); tgt unchanged.
  - Miss, taken: allocate; v <= 1, tag <= upd tag, tgt <= upd_target, ctr <= 2'b10. Any previous occupant is replaced.
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same idx: the lookup sees pre-update contents; there is no bypass. The update is never lost.
- Aliasing: distinct PCs with equal idx and tag share an entry. This is accepted and is not an error.
- Reset asserted mid-operation: outputs clear immediately; no stale pred_valid after release.
- Correctness does not depend on prediction; EX compares pred_taken/pred_target with its resolution and raises flush.

Decomposition:
- defines.v gains:
  - `ysyx_22040931_PC_BUS
  - `ysyx_22040931_CTR_SNT/WNT/WT/ST (2'b00..2'b11)
  - `ysyx_22040931_BTB_ENTRIES default
- One sub-module, ysyx_22040931_sat_ctr2: combinational 2-bit saturating next-state from (ctr, taken). Instantiated once on the update path.
- Storage is flop arrays inside the top module; no SRAM macro.

Test Plan:
- Reset then lookup: release rst_n, req_pc=0x8000_0000 → next cycle pred_valid=1, pred_taken=0, pred_target=0x8000_0004.
- Allocate: upd_valid, upd_pc=0x8000_0010, upd_taken=1, upd_target=0x8000_0100; then req_pc=0x8000_0010 → pred_taken=1, pred_target=0x8000_0100 (ctr=10).
- Counter hysteresis: from ctr=10, two not-taken updates → ctr=00, prediction not-taken. Then one taken → ctr=01, still not-taken. A second taken → 10, taken. Also check 11 stays 11 on further taken updates.
- Tag conflict: train 0x8000_0010 taken; lookup 0x8000_0410 (same idx, different tag) → pred_taken=0, target 0x8000_0414. Taken update at 0x8000_0410 replaces the entry, and 0x8000_0010 then misses.
- Same-cycle hazard: lookup and allocating update of 0x8000_0020 in one cycle → that prediction is not-taken; the repeated lookup next cycle is taken.
- Stall/flush: stall=1 for 3 cycles with changing req_pc → pred_* frozen. flush=1 with stall=1 → pred_valid=0 next cycle. rst_n pulsed mid-stream → all predictions not-taken afterwards.
